// File: rtl/i2c_arbiter.sv
//------------------------------------------------------------------------------
// i2c_arbiter : round-robin sharing of one I2C master between N requesters,
//               with bus-idle guard and stalled-requester timeout abort.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module i2c_arbiter #(
  parameter int N            = 2,
  parameter int HOLD_TIMEOUT = 65535,
  parameter int GUARD        = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_cmd_active,
  input  logic [7*N-1:0] req_cmd_addr,
  input  logic [N-1:0]   req_cmd_read,
  input  logic [N-1:0]   req_cmd_high_speed,
  input  logic [N-1:0]   req_read_nack,
  input  logic [N-1:0]   req_data_valid,
  input  logic [8*N-1:0] req_data_in,
  output logic [N-1:0]   req_data_ready,
  output logic [7:0]     req_data_out,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   abort,
  output logic           m_cmd_active,
  output logic [6:0]     m_cmd_addr,
  output logic           m_cmd_read,
  output logic           m_cmd_high_speed,
  output logic           m_read_nack,
  output logic           m_data_valid,
  output logic [7:0]     m_data_in,
  input  logic           m_data_ready,
  input  logic [7:0]     m_data_out,
  input  logic           m_busy
);

  localparam int c_IW = $clog2(N);
  localparam int c_HW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam int c_GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [c_IW-1:0] c_LAST_RST   = c_IW'(N - 1);
  localparam logic [c_HW-1:0] c_HOLD_LAST  = c_HW'(HOLD_TIMEOUT - 1);
  localparam logic [c_GW-1:0] c_GUARD_LAST = c_GW'(GUARD - 1);
  localparam logic [N-1:0]    c_ONE        = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t            r_state;
  logic [N-1:0]      r_grant;
  logic [N-1:0]      r_abort;
  logic [N-1:0]      r_lockout;
  logic [c_IW-1:0]   r_gidx;
  logic [c_IW-1:0]   r_last;
  logic [c_HW-1:0]   r_hold;
  logic [c_GW-1:0]   r_guard;

  logic [N-1:0]      w_eligible;
  logic              w_pick_valid;
  logic [c_IW-1:0]   w_pick;
  logic              w_in_grant;
  logic              w_req_live;
  logic              w_timeout;
  logic              w_guard_done;

  function automatic logic [c_IW-1:0] f_wrap(input logic [c_IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return c_IW'(s);
  endfunction

  assign w_eligible = req_cmd_active & ~r_lockout;

  // Scan starts just after the last owner so every requester gets its turn.
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick       = r_last;
    for (int k = 1; k <= N; k++) begin
      if (!w_pick_valid && w_eligible[f_wrap(r_last, k)]) begin
        w_pick_valid = 1'b1;
        w_pick       = f_wrap(r_last, k);
      end
    end
  end

  assign w_in_grant   = (r_state == S_GRANT);
  assign w_req_live   = req_cmd_active[r_gidx];
  assign w_timeout    = (HOLD_TIMEOUT != 0) && !m_data_ready && (r_hold == c_HOLD_LAST);
  assign w_guard_done = (GUARD == 0) || (r_guard == c_GUARD_LAST);

  always_comb begin
    m_cmd_active     = 1'b0;
    m_cmd_addr       = 7'd0;
    m_cmd_read       = 1'b0;
    m_cmd_high_speed = 1'b0;
    m_read_nack      = 1'b0;
    m_data_valid     = 1'b0;
    m_data_in        = 8'd0;
    req_data_ready   = '0;
    if (w_in_grant) begin
      m_cmd_active     = w_req_live;
      m_cmd_addr       = req_cmd_addr[int'(r_gidx)*7 +: 7];
      m_cmd_read       = req_cmd_read[r_gidx];
      m_cmd_high_speed = req_cmd_high_speed[r_gidx];
      m_read_nack      = req_read_nack[r_gidx];
      m_data_valid     = req_data_valid[r_gidx];
      m_data_in        = req_data_in[int'(r_gidx)*8 +: 8];
      req_data_ready   = r_grant & {N{m_data_ready}};
    end
  end

  assign grant        = r_grant;
  assign abort        = r_abort;
  assign req_data_out = m_data_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_abort   <= '0;
      r_lockout <= '0;
      r_gidx    <= '0;
      r_last    <= c_LAST_RST;
      r_hold    <= '0;
      r_guard   <= '0;
    end else begin
      r_abort   <= '0;
      r_lockout <= r_lockout & req_cmd_active;
      case (r_state)
        S_IDLE: begin
          if (w_pick_valid && !m_busy) begin
            r_state <= S_GRANT;
            r_gidx  <= w_pick;
            r_grant <= c_ONE << w_pick;
            r_hold  <= '0;
          end
        end
        S_GRANT: begin
          // A normal release wins over a timeout landing in the same cycle.
          if (!w_req_live) begin
            r_state <= S_RELEASE;
            r_last  <= r_gidx;
            r_grant <= '0;
            r_guard <= '0;
          end else if (w_timeout) begin
            r_state   <= S_RELEASE;
            r_last    <= r_gidx;
            r_grant   <= '0;
            r_guard   <= '0;
            r_abort   <= r_grant;
            r_lockout <= (r_lockout | r_grant) & req_cmd_active;
          end else if (m_data_ready) begin
            r_hold <= '0;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        S_RELEASE: begin
          if (m_busy) begin
            r_guard <= '0;
          end else if (w_guard_done) begin
            r_state <= S_IDLE;
            r_guard <= '0;
          end else begin
            r_guard <= r_guard + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_arbiter.sv
//------------------------------------------------------------------------------
// tb_i2c_arbiter : directed scoreboard bench for i2c_arbiter (N=3, timeout 16).
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_i2c_arbiter;

  localparam int N  = 3;
  localparam int HT = 16;
  localparam int GD = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_cmd_active;
  logic [7*N-1:0] req_cmd_addr;
  logic [N-1:0]   req_cmd_read;
  logic [N-1:0]   req_cmd_high_speed;
  logic [N-1:0]   req_read_nack;
  logic [N-1:0]   req_data_valid;
  logic [8*N-1:0] req_data_in;
  logic [N-1:0]   req_data_ready;
  logic [7:0]     req_data_out;
  logic [N-1:0]   grant;
  logic [N-1:0]   abort;
  logic           m_cmd_active;
  logic [6:0]     m_cmd_addr;
  logic           m_cmd_read;
  logic           m_cmd_high_speed;
  logic           m_read_nack;
  logic           m_data_valid;
  logic [7:0]     m_data_in;
  logic           m_data_ready;
  logic [7:0]     m_data_out;
  logic           m_busy;

  i2c_arbiter #(.N(N), .HOLD_TIMEOUT(HT), .GUARD(GD)) dut (
    .clk(clk), .reset(reset),
    .req_cmd_active(req_cmd_active), .req_cmd_addr(req_cmd_addr),
    .req_cmd_read(req_cmd_read), .req_cmd_high_speed(req_cmd_high_speed),
    .req_read_nack(req_read_nack), .req_data_valid(req_data_valid),
    .req_data_in(req_data_in), .req_data_ready(req_data_ready),
    .req_data_out(req_data_out), .grant(grant), .abort(abort),
    .m_cmd_active(m_cmd_active), .m_cmd_addr(m_cmd_addr),
    .m_cmd_read(m_cmd_read), .m_cmd_high_speed(m_cmd_high_speed),
    .m_read_nack(m_read_nack), .m_data_valid(m_data_valid),
    .m_data_in(m_data_in), .m_data_ready(m_data_ready),
    .m_data_out(m_data_out), .m_busy(m_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] g;
    logic [6:0] addr;
    logic       rd;
  } gexp_t;

  gexp_t      gq[$];
  logic [2:0] aq[$];
  logic [7:0] bq0[$];
  logic [7:0] bq1[$];
  logic [7:0] bq2[$];

  int tests_run    = 0;
  int tests_failed = 0;

  int         rem[N];
  logic [2:0] auto_drop;
  logic [2:0] hs;
  logic       busy_int;
  logic       busy_force;
  int         tail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expectation matching each grant, byte handshake and abort.
  initial begin
    logic [2:0] prev_grant;
    gexp_t      e;
    logic [7:0] b;
    logic       have;
    prev_grant = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_grant = '0;
      end else begin
        if (prev_grant == 3'b000 && grant != 3'b000) begin
          if (gq.size() == 0) begin
            chk("unexpected_grant", 32'(grant), 0);
          end else begin
            e = gq.pop_front();
            chk("grant_order", 32'(grant), 32'(e.g));
            chk("grant_addr", 32'(m_cmd_addr), 32'(e.addr));
            chk("grant_read", 32'(m_cmd_read), 32'(e.rd));
            chk("grant_cmd_active", 32'(m_cmd_active), 1);
          end
        end
        if (req_data_ready != 3'b000) begin
          chk("ready_routing", 32'(req_data_ready), 32'(grant));
          have = 1'b0;
          b    = 8'h00;
          if (grant == 3'b001 && bq0.size() > 0) begin b = bq0.pop_front(); have = 1'b1; end
          if (grant == 3'b010 && bq1.size() > 0) begin b = bq1.pop_front(); have = 1'b1; end
          if (grant == 3'b100 && bq2.size() > 0) begin b = bq2.pop_front(); have = 1'b1; end
          if (!have) chk("unexpected_byte", 32'(req_data_ready), 0);
          else       chk("byte_data", 32'(m_data_in), 32'(b));
        end
        if (abort != 3'b000) begin
          if (aq.size() == 0) chk("unexpected_abort", 32'(abort), 0);
          else                chk("abort_vec", 32'(abort), 32'(aq.pop_front()));
        end
        prev_grant = grant;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // One clock: requesters advance on handshakes, then a simple master reacts.
  task automatic step();
    @(negedge clk);
    hs = req_data_ready & req_data_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        rem[i]--;
        if (rem[i] <= 0) begin
          req_data_valid[i] = 1'b0;
          if (auto_drop[i]) req_cmd_active[i] = 1'b0;
        end else begin
          req_data_in[8*i +: 8] = req_data_in[8*i +: 8] + 8'd1;
        end
      end
    end
    #1;
    if (m_cmd_active) begin
      busy_int     = 1'b1;
      tail         = 2;
      m_data_ready = m_data_valid & ~m_data_ready;
    end else begin
      m_data_ready = 1'b0;
      if (tail > 0) tail--;
      else          busy_int = 1'b0;
    end
    m_busy = busy_int | busy_force;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_grant(input logic [2:0] target, input string name, input int limit);
    int n;
    n = 0;
    while (grant !== target && n < limit) begin
      step();
      n++;
    end
    if (grant !== target) chk(name, 32'(grant), 32'(target));
  endtask

  task automatic push_grant(input logic [2:0] g, input logic [6:0] addr, input logic rd);
    gq.push_back({g, addr, rd});
  endtask

  task automatic start_xact(input int i, input logic [6:0] addr, input logic rd,
                            input int nbytes, input logic [7:0] base, input logic drop);
    req_cmd_addr[7*i +: 7]  = addr;
    req_cmd_read[i]         = rd;
    req_cmd_high_speed[i]   = 1'b0;
    req_read_nack[i]        = rd;
    req_data_in[8*i +: 8]   = base;
    req_data_valid[i]       = (nbytes > 0);
    rem[i]                  = nbytes;
    auto_drop[i]            = drop;
    req_cmd_active[i]       = 1'b1;
    for (int k = 0; k < nbytes; k++) begin
      case (i)
        0:       bq0.push_back(base + 8'(k));
        1:       bq1.push_back(base + 8'(k));
        default: bq2.push_back(base + 8'(k));
      endcase
    end
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    req_cmd_active     = '0;
    req_cmd_addr       = '0;
    req_cmd_read       = '0;
    req_cmd_high_speed = '0;
    req_read_nack      = '0;
    req_data_valid     = '0;
    req_data_in        = '0;
    m_data_ready       = 1'b0;
    busy_int           = 1'b0;
    busy_force         = 1'b0;
    tail               = 0;
    m_busy             = 1'b0;
    auto_drop          = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int lim;
    int cnt[N];
    logic [2:0] wf;
    m_data_out = 8'h3C;

    // Reset state
    do_reset();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_abort", 32'(abort), 0);
    chk("rst_m_cmd_active", 32'(m_cmd_active), 0);
    chk("rst_m_cmd_addr", 32'(m_cmd_addr), 0);
    chk("rst_m_data_valid", 32'(m_data_valid), 0);
    chk("rst_req_data_ready", 32'(req_data_ready), 0);

    // Single requester, 3-byte write to 0x60
    start_xact(0, 7'h60, 1'b0, 3, 8'h10, 1'b1);
    push_grant(3'b001, 7'h60, 1'b0);
    step();
    chk("t1_latency_grant", 32'(grant), 1);
    chk("t1_m_cmd_active", 32'(m_cmd_active), 1);
    chk("t1_m_cmd_addr", 32'(m_cmd_addr), 32'h60);
    wait_grant(3'b000, "t1_release_timeout", 50);
    chk("t1_release_cmd_low", 32'(m_cmd_active), 0);
    steps(12);
    chk("t1_bytes_left", 32'(bq0.size()), 0);

    // Simultaneous req0/req1 after reset: req0 first, req1 after guard
    do_reset();
    start_xact(0, 7'h21, 1'b0, 2, 8'h20, 1'b1);
    start_xact(1, 7'h22, 1'b0, 1, 8'h30, 1'b1);
    push_grant(3'b001, 7'h21, 1'b0);
    push_grant(3'b010, 7'h22, 1'b0);
    step();
    chk("t2_first_grant", 32'(grant), 1);
    wait_grant(3'b000, "t2_release_timeout", 50);
    n = 0;
    while (m_busy !== 1'b0 && n < 20) begin step(); n++; end
    chk("t2_busy_fell", 32'(m_busy), 0);
    n = 0;
    while (grant === 3'b000 && n < 20) begin step(); n++; end
    chk("t2_guard_cycles", 32'(n), 32'(GD + 1));
    chk("t2_second_grant", 32'(grant), 2);
    wait_grant(3'b000, "t2_release2_timeout", 50);
    steps(12);

    // Fairness: all three requesting continuously, 1-byte transactions
    do_reset();
    wf = '0;
    for (int i = 0; i < N; i++) begin
      start_xact(i, 7'h40 + 7'(i), 1'b0, 1, 8'(16 * (i + 1)), 1'b1);
      cnt[i] = 1;
    end
    for (int r = 0; r < 2; r++) begin
      push_grant(3'b001, 7'h40, 1'b0);
      push_grant(3'b010, 7'h41, 1'b0);
      push_grant(3'b100, 7'h42, 1'b0);
    end
    lim = 0;
    while (lim < 400 && !(cnt[0] == 2 && cnt[1] == 2 && cnt[2] == 2 && req_cmd_active == 3'b000)) begin
      step();
      lim++;
      for (int i = 0; i < N; i++) begin
        if (!req_cmd_active[i] && cnt[i] < 2) begin
          if (wf[i]) begin
            start_xact(i, 7'h40 + 7'(i), 1'b0, 1, 8'(16 * (i + 1) + 8), 1'b1);
            cnt[i]++;
            wf[i] = 1'b0;
          end else begin
            wf[i] = 1'b1;
          end
        end
      end
    end
    chk("t3_completed", 32'(lim < 400), 1);
    steps(12);
    chk("t3_all_grants_seen", 32'(gq.size()), 0);

    // m_busy held high in IDLE blocks the grant
    busy_force = 1'b1;
    m_busy     = 1'b1;
    start_xact(1, 7'h55, 1'b1, 1, 8'h77, 1'b1);
    push_grant(3'b010, 7'h55, 1'b1);
    steps(10);
    chk("t4_no_grant_busy", 32'(grant), 0);
    busy_force = 1'b0;
    m_busy     = busy_int;
    step();
    chk("t4_grant_after_idle", 32'(grant), 2);
    chk("t4_read_nack", 32'(m_read_nack), 1);
    m_data_out = 8'hA5;
    #1;
    chk("t4_data_out", 32'(req_data_out), 32'hA5);
    wait_grant(3'b000, "t4_release_timeout", 50);
    steps(12);

    // Timeout: req0 stalls, gets aborted and locked out; req1 proceeds
    do_reset();
    start_xact(0, 7'h11, 1'b0, 0, 8'h00, 1'b0);
    start_xact(1, 7'h12, 1'b0, 1, 8'h50, 1'b1);
    push_grant(3'b001, 7'h11, 1'b0);
    push_grant(3'b010, 7'h12, 1'b0);
    aq.push_back(3'b001);
    step();
    chk("t5_first_grant", 32'(grant), 1);
    n = 0;
    while (m_cmd_active === 1'b1 && n < 100) begin n++; step(); end
    chk("t5_timeout_cycles", 32'(n), 32'(HT));
    chk("t5_abort_pulse", 32'(abort), 1);
    chk("t5_grant_revoked", 32'(grant), 0);
    step();
    chk("t5_abort_one_cycle", 32'(abort), 0);
    wait_grant(3'b010, "t5_req1_grant_timeout", 40);
    wait_grant(3'b000, "t5_req1_release_timeout", 40);
    steps(20);
    chk("t5_lockout_holds", 32'(grant), 0);
    req_cmd_active[0] = 1'b0;
    step();
    start_xact(0, 7'h11, 1'b0, 1, 8'h60, 1'b1);
    push_grant(3'b001, 7'h11, 1'b0);
    wait_grant(3'b001, "t5_regrant_timeout", 20);
    wait_grant(3'b000, "t5_regrant_release_timeout", 40);
    steps(12);

    // Asynchronous reset in the middle of a grant
    start_xact(1, 7'h33, 1'b0, 0, 8'h00, 1'b0);
    push_grant(3'b010, 7'h33, 1'b0);
    step();
    chk("t6_pre_grant", 32'(grant), 2);
    step();
    reset = 1'b1;
    #1;
    chk("t6_async_grant", 32'(grant), 0);
    chk("t6_async_m_cmd_active", 32'(m_cmd_active), 0);
    do_reset();
    start_xact(0, 7'h44, 1'b0, 1, 8'h90, 1'b1);
    start_xact(1, 7'h45, 1'b0, 1, 8'hA0, 1'b1);
    push_grant(3'b001, 7'h44, 1'b0);
    push_grant(3'b010, 7'h45, 1'b0);
    step();
    chk("t6_restart_prio", 32'(grant), 1);
    lim = 0;
    while (req_cmd_active !== 3'b000 && lim < 100) begin step(); lim++; end
    chk("t6_both_done", 32'(req_cmd_active), 0);
    steps(12);

    chk("grant_queue_empty", 32'(gq.size()), 0);
    chk("abort_queue_empty", 32'(aq.size()), 0);
    chk("byte_queues_empty", 32'(bq0.size() + bq1.size() + bq2.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
